// File: rtl/sample_com_bin_dec.sv
// Binary index to one-hot (ACT=1) or one-cold (ACT=0) decoder with a registered output.
// Each output bit is its own compare-and-flop cell. Nothing combinational reaches the ports.

module sample_com_bin_dec_bit #(
    parameter int IN  = 4,
    parameter int IDX = 0,
    parameter bit ACT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IN-1:0] in,
    input  logic          en,
    output logic          q
);
    localparam logic [IN-1:0] SEL = IN'(IDX);

    logic dec;

    // The condition is left unmasked, so an X/Z index gives X here.
    assign dec = (in == SEL) ? ACT : ~ACT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= ~ACT;
        else if (en)
            q <= dec;
    end
endmodule

module sample_com_bin_dec #(
    parameter int IN  = 4,
    parameter int OUT = 1 << IN,
    parameter bit ACT = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IN-1:0]  in,
    input  logic           en,
    output logic [OUT-1:0] out,
    output logic           out_valid
);
    for (genvar g = 0; g < OUT; g++) begin : g_bit
        sample_com_bin_dec_bit #(
            .IN  (IN),
            .IDX (g),
            .ACT (ACT)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .in    (in),
            .en    (en),
            .q     (out[g])
        );
    end

    // The flag is sticky. It only falls on reset, because a capture always leaves one bit active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_valid <= 1'b0;
        else if (en)
            out_valid <= 1'b1;
    end
endmodule

// File: tb/tb_sample_com_bin_dec.sv
// Scoreboard bench for sample_com_bin_dec. It covers IN=4 and IN=1, each with ACT=1 and ACT=0.
// Stimulus queues one expectation per cycle. The monitor checks it 1 ns after the edge.

module tb_sample_com_bin_dec;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  c;
        logic [1:0]  d;
        logic        v;
    } exp_t;

    localparam logic [15:0] HOT [16] = '{
        16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
        16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000};

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  in4;
    logic [0:0]  in1;
    logic [15:0] out_a, out_b;
    logic [1:0]  out_c, out_d;
    logic        v_a, v_b, v_c, v_d;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    assign in1 = in4[0:0];

    sample_com_bin_dec #(.IN(4), .ACT(1'b1)) u_a (.clk(clk), .reset(reset), .in(in4), .en(en), .out(out_a), .out_valid(v_a));
    sample_com_bin_dec #(.IN(4), .ACT(1'b0)) u_b (.clk(clk), .reset(reset), .in(in4), .en(en), .out(out_b), .out_valid(v_b));
    sample_com_bin_dec #(.IN(1), .ACT(1'b1)) u_c (.clk(clk), .reset(reset), .in(in1), .en(en), .out(out_c), .out_valid(v_c));
    sample_com_bin_dec #(.IN(1), .ACT(1'b0)) u_d (.clk(clk), .reset(reset), .in(in1), .en(en), .out(out_d), .out_valid(v_d));

    function automatic exp_t mk(input logic [3:0] k, input logic v);
        exp_t x;
        x.a = v ? HOT[k]  : 16'h0000;
        x.b = v ? ~HOT[k] : 16'hFFFF;
        x.c = v ? (k[0] ? 2'b10 : 2'b01) : 2'b00;
        x.d = v ? (k[0] ? 2'b01 : 2'b10) : 2'b11;
        x.v = v;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t x);
        chk({tag, " act1 in4 out"}, out_a, x.a);
        chk({tag, " act0 in4 out"}, out_b, x.b);
        chk({tag, " act1 in1 out"}, {14'd0, out_c}, {14'd0, x.c});
        chk({tag, " act0 in1 out"}, {14'd0, out_d}, {14'd0, x.d});
        chk({tag, " valid"}, {12'd0, v_a, v_b, v_c, v_d}, {12'd0, {4{x.v}}});
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) chk_all("sb", q.pop_front());
        end
    end

    // Each call drives one cycle of inputs and queues the state expected after the next edge.
    task automatic drive(input logic r, input logic e, input logic [3:0] i, input exp_t x);
        reset = r;
        en    = e;
        in4   = i;
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset is asserted with a live index and en=1. The clear must show before any clock edge.
        reset = 1'b1; en = 1'b1; in4 = 4'h5;
        #1;
        chk_all("reset immediate", mk(4'h0, 1'b0));
        @(posedge clk);
        #2;
        for (int n = 0; n < 3; n++) drive(1'b1, 1'b1, 4'h5, mk(4'h0, 1'b0));

        // Full sweep. The first capture lands on the first edge after release.
        for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, 4'(k), mk(4'(k), 1'b1));

        // Enable hold
        drive(1'b0, 1'b1, 4'h3, mk(4'h3, 1'b1));
        for (int n = 0; n < 4; n++) drive(1'b0, 1'b0, 4'h9, mk(4'h3, 1'b1));
        drive(1'b0, 1'b1, 4'h9, mk(4'h9, 1'b1));

        // Async reset pulse mid-stream, with out at 16'h0100
        drive(1'b0, 1'b1, 4'h8, mk(4'h8, 1'b1));
        reset = 1'b1;
        #1;
        chk_all("midstream reset", mk(4'h0, 1'b0));
        reset = 1'b0;
        #1;
        drive(1'b0, 1'b0, 4'h8, mk(4'h0, 1'b0));
        drive(1'b0, 1'b1, 4'h6, mk(4'h6, 1'b1));
        drive(1'b0, 1'b1, 4'hA, mk(4'hA, 1'b1));
        drive(1'b0, 1'b1, 4'hF, mk(4'hF, 1'b1));
        en = 1'b0;

        // Drain the queue within a bounded number of cycles
        for (int n = 0; n < 10 && q.size() != 0; n++) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sample_com_bin_dec.md
# sample_com_bin_dec

Parameterised binary-to-one-hot decoder with a registered output stage. It takes an IN-bit binary index and drives an OUT = 2^IN bit vector. Exactly one bit, the one selected by the index, is at the active level ACT; all other bits are at the inactive level. It serves as a common select/enable generator (row select, bank enable, write-strobe fan-out) in the datapath.

## Interface
Parameters:
- IN, default 4: width of the binary index; legal range 1..8.
- OUT, default 1 << IN: output width; derived, never overridden.
- ACT, default 1 (High): active level of the selected output bit.
  - ACT=1 gives one-hot output.
  - ACT=0 gives one-cold output.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk, input, 1: clock; all state updates on the rising edge.
  - reset, input, 1: asynchronous, active-high reset.
- in, input, IN: binary index to decode.
- en, input, 1: capture enable; active-high.
- out, output, OUT: decoded vector; registered.
- out_valid, output, 1: high once out holds a decode of a captured index.

## Operation
- Decode rule:
  - out[i] = ACT when the captured index equals i.
  - out[i] = ~ACT otherwise, for i = 0..OUT-1.
- Exactly one bit of out is at ACT whenever out_valid=1.
- Capture:
  - When en=1 at a rising clk edge, the decode of in is loaded into out, and out_valid is set to 1.
  - When en=0, out and out_valid hold their current values.
- Reset state:
  - Asserting reset at any time forces every bit of out to ~ACT (all inactive) and out_valid to 0.
  - No bit is at ACT while out_valid=0.
- Index range: every IN-bit value is a legal index. No out-of-range case exists and there is no wrap logic.
- Unknown input: if in contains X/Z while en=1, out becomes X. No X-masking is performed.
- The decode is purely combinational from in to the register D input; there is no internal FSM.

## Timing
- Latency: 1 cycle. An index presented with en=1 before rising edge N appears on out after edge N.
- Throughput: one new index per cycle; back-to-back changes are allowed.
- out and out_valid are driven directly from flops, with no combinational path from inputs to outputs.
- Reset assertion:
  - Takes effect immediately, with no clock required.
  - The output clear is visible within the same delta/propagation time.
- Reset release: the first capture occurs on the first rising edge with reset=0 and en=1.
- Reset mid-operation: a reset pulse between edges clears out to all-inactive; any previously captured index is lost.
- Simultaneous reset and en on the same edge: reset wins; out stays all-inactive and out_valid stays 0.

## Test plan
- Reset check, ACT=1, IN=4:
  - Stimulus: assert reset with in=4'h5, en=1.
  - Required: out=16'h0000 and out_valid=0 immediately, and they remain so on every edge while reset is held.
- Full sweep, ACT=1:
  - Stimulus: en=1; drive in = 0..15, one per cycle.
  - Required: one cycle later, out = 16'h0001 << in, each with out_valid=1; e.g. in=4'hA gives out=16'h0400.
- Active-low sweep, ACT=0:
  - Stimulus: repeat the full sweep.
  - Required: out = ~(16'h0001 << in); e.g. in=0 gives 16'hFFFE, in=15 gives 16'h7FFF. Reset value is 16'hFFFF.
- Enable hold:
  - Stimulus: capture in=3, then set en=0 and change in to 9 for 4 cycles.
  - Required: out stays 16'h0008; re-asserting en loads 16'h0200 one cycle later.
- Asynchronous reset mid-stream:
  - Stimulus: while out=16'h0100, pulse reset between clock edges.
  - Required: out=16'h0000 and out_valid=0 before the next edge; the next capture resumes normally.
- Width corner, IN=1:
  - Stimulus: in=0, then in=1.
  - Required: out=2'b01, then out=2'b10; with ACT=0, out=2'b10, then out=2'b01.
